// File: rtl/pnu_clk_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Mode encodings, the minimum legal divisor and a width helper for the channel address.
package pnu_clk_pkg;

  localparam int   MIN_DIV      = 2;
  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pnu_clk_div_ch.sv
// One divider channel: shadow/active divisor and mode, period counter, enable edge
// register and registered div_clk/tick/busy outputs.
module pnu_clk_div_ch
  import pnu_clk_pkg::*;
#(
  parameter int CNT_W   = 20,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             div_clk,
  output logic             tick,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_sh;
  logic             mode_act;
  logic             mode_sh;
  logic             en_d;
  logic             os_run;

  logic             running;
  logic             wrap;
  logic             reload;
  logic [CNT_W-1:0] div_next;
  logic             mode_next;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d;
  endfunction

  // A write landing on the wrap cycle bypasses the shadow so it governs the very next period.
  always_comb begin
    wrap      = (cnt == (div_act - CNT_W'(1)));
    running   = en && ((mode_act == MODE_CONT) || os_run || !en_d);
    reload    = !running || wrap;
    div_next  = cfg_we ? clamp_div(cfg_div) : div_sh;
    mode_next = cfg_we ? cfg_mode : mode_sh;
  end

  // Output stage: everything below is registered from the current count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= CNT_W'(DEF_DIV);
      div_sh   <= CNT_W'(DEF_DIV);
      mode_act <= MODE_CONT;
      mode_sh  <= MODE_CONT;
      en_d     <= 1'b0;
      os_run   <= 1'b0;
      div_clk  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      en_d <= en;
      if (cfg_we) begin
        div_sh  <= clamp_div(cfg_div);
        mode_sh <= cfg_mode;
      end
      if (reload) begin
        div_act  <= div_next;
        mode_act <= mode_next;
      end
      cnt     <= (running && !wrap) ? cnt + CNT_W'(1) : '0;
      os_run  <= running && !wrap;
      div_clk <= running && (cnt >= (div_act >> 1));
      tick    <= running && wrap;
      busy    <= running;
    end
  end

endmodule

// File: rtl/pnu_clk_div_multi.sv
// Multi-channel programmable clock-enable / divided-clock generator.
// Decodes the config address, fans out write enables and gathers channel outputs.
module pnu_clk_div_multi
  import pnu_clk_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int CNT_W   = 20,
  parameter  int DEF_DIV = 2,
  localparam int CH_W    = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  div_clk,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  logic [N_CH-1:0] we_ch;

  // Addresses at or above N_CH match no channel, so such writes vanish.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign we_ch[g] = cfg_we && (cfg_ch == CH_W'(g));

    pnu_clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .cfg_we   (we_ch[g]),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .div_clk  (div_clk[g]),
      .tick     (tick[g]),
      .busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_pnu_clk_div_multi.sv
// Directed scoreboard bench for pnu_clk_div_multi with three channels.
module tb_pnu_clk_div_multi;

  localparam int N_CH  = 3;
  localparam int CNT_W = 20;

  logic             clk;
  logic             rst_n;
  logic [N_CH-1:0]  en;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [N_CH-1:0]  div_clk;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  busy;

  pnu_clk_div_multi #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .div_clk  (div_clk),
    .tick     (tick),
    .busy     (busy)
  );

  typedef struct {
    string      tag;
    logic [2:0] dc;
    logic [2:0] tk;
    logic [2:0] bz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic clk_check();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".div_clk"}, div_clk, e.dc);
      chk({e.tag, ".tick"},    tick,    e.tk);
      chk({e.tag, ".busy"},    busy,    e.bz);
    end
  endtask

  function automatic logic [1:0] phase_bits(input int div, input int k);
    int p;
    p = k % div;
    return {1'(p >= div / 2), 1'(p == div - 1)};
  endfunction

  task automatic run(input logic [2:0] mask, input int d0, input int d1, input int d2,
                     input int k0, input int n, input string tag);
    int         d[3];
    exp_t       e;
    logic [1:0] b;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int k = 0; k < n; k++) begin
      e.tag = tag; e.dc = '0; e.tk = '0; e.bz = '0;
      for (int c = 0; c < 3; c++) begin
        if (mask[c]) begin
          b = phase_bits(d[c], k0 + k);
          e.dc[c] = b[1];
          e.tk[c] = b[0];
          e.bz[c] = 1'b1;
        end
      end
      q.push_back(e);
      clk_check();
    end
  endtask

  task automatic idle(input int n, input string tag);
    run(3'b000, 2, 2, 2, 0, n, tag);
  endtask

  task automatic cfg_set(input int ch, input int div, input logic mode);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = CNT_W'(div);
    cfg_mode = mode;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

    // T1: reset values, default divisor 2, asynchronous reset mid-count
    #12;
    chk("t1_rst.div_clk", div_clk, 3'b000);
    chk("t1_rst.tick", tick, 3'b000);
    chk("t1_rst.busy", busy, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    en = 3'b001;
    run(3'b001, 2, 2, 2, 0, 6, "t1_div2");
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async.div_clk", div_clk, 3'b000);
    chk("t1_async.busy", busy, 3'b000);
    chk("t1_async.tick", tick, 3'b000);
    @(negedge clk);
    chk("t1_hold.div_clk", div_clk, 3'b000);
    chk("t1_hold.busy", busy, 3'b000);
    rst_n = 1'b1;
    run(3'b001, 2, 2, 2, 0, 4, "t1_restart");
    en = 3'b000;
    idle(1, "t1_off");

    // T2: odd divisor 5 on channel 1
    cfg_set(1, 5, 1'b0);
    idle(1, "t2_cfg");
    cfg_we = 1'b0;
    en = 3'b010;
    run(3'b010, 2, 5, 2, 0, 15, "t2_div5");
    en = 3'b000;
    idle(1, "t2_off");

    // T3: reloads never disturb a running period
    cfg_set(0, 8, 1'b0);
    idle(1, "t3_cfg");
    cfg_we = 1'b0;
    en = 3'b001;
    run(3'b001, 8, 2, 2, 0, 3, "t3_p8a");
    cfg_set(0, 4, 1'b0);
    run(3'b001, 8, 2, 2, 3, 1, "t3_wr_mid");
    cfg_we = 1'b0;
    run(3'b001, 8, 2, 2, 4, 4, "t3_p8b");
    run(3'b001, 4, 2, 2, 0, 11, "t3_p4");
    cfg_set(0, 8, 1'b0);
    run(3'b001, 4, 2, 2, 3, 1, "t3_wr_wrap4");
    cfg_we = 1'b0;
    run(3'b001, 8, 2, 2, 0, 15, "t3_p8c");
    cfg_set(0, 4, 1'b0);
    run(3'b001, 8, 2, 2, 7, 1, "t3_wr_wrap8");
    cfg_we = 1'b0;
    run(3'b001, 4, 2, 2, 0, 8, "t3_p4b");
    en = 3'b000;
    idle(1, "t3_off");

    // T4: one-shot divisor 6 on channel 2
    cfg_set(2, 6, 1'b1);
    idle(1, "t4_cfg");
    cfg_we = 1'b0;
    en = 3'b100;
    run(3'b100, 2, 2, 6, 0, 6, "t4_shot1");
    idle(4, "t4_held");
    en = 3'b000;
    idle(1, "t4_low");
    en = 3'b100;
    run(3'b100, 2, 2, 6, 0, 6, "t4_shot2");
    idle(3, "t4_held2");
    en = 3'b000;
    idle(1, "t4_off");

    // T5: clamp of divisor 0, write to nonexistent channel ignored
    cfg_set(2, 0, 1'b0);
    idle(1, "t5_cfg0");
    cfg_we = 1'b0;
    en = 3'b100;
    run(3'b100, 2, 2, 2, 0, 6, "t5_clamp");
    en = 3'b000;
    idle(1, "t5_off");
    cfg_set(3, 7, 1'b1);
    idle(1, "t5_cfg3");
    cfg_we = 1'b0;
    en = 3'b111;
    run(3'b111, 4, 5, 2, 0, 20, "t5_ignore");
    en = 3'b000;
    idle(1, "t5_off2");

    // T6: abort a continuous period and restart from zero
    cfg_set(0, 10, 1'b0);
    idle(1, "t6_cfg");
    cfg_we = 1'b0;
    en = 3'b001;
    run(3'b001, 10, 2, 2, 0, 4, "t6_pre");
    en = 3'b000;
    idle(2, "t6_abort");
    en = 3'b001;
    run(3'b001, 10, 2, 2, 0, 12, "t6_restart");
    en = 3'b000;
    idle(1, "t6_off");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
